// File: rtl/instruction_utils.sv
// Decoded RV32I instruction identifiers shared by the decoder and the control sequencer.
package instruction_utils;

  typedef enum logic [5:0] {
    I_LUI, I_AUIPC, I_JAL, I_JALR,
    I_BEQ, I_BNE, I_BLT, I_BGE, I_BLTU, I_BGEU,
    I_LB, I_LH, I_LW, I_LBU, I_LHU,
    I_SB, I_SH, I_SW,
    I_ADDI, I_SLTI, I_SLTIU, I_XORI, I_ORI, I_ANDI, I_SLLI, I_SRLI, I_SRAI,
    I_ADD, I_SUB, I_SLL, I_SLT, I_SLTU, I_XOR, I_SRL, I_SRA, I_OR, I_AND
  } rv32i_instr_e;

endpackage

// File: rtl/core_ctrl_fsm.sv
// Multi-cycle control sequencer for the RV32I core: drives datapath enables/selects
// through FETCH/DECODE/EXEC/MEM/WB, counts retired instructions, traps on faults.
//
// state  | meaning
// IDLE   | waiting for run
// FETCH  | imem_req held until imem_ready, IR loaded on ready
// DECODE | operands/imm latched, illegal check
// EXEC   | ALU/jump/branch retire here; loads/stores move on to MEM
// MEM    | dmem_req held until dmem_ready; stores retire here
// WB     | load data written back, retire
// TRAP   | sticky halt, left only through rst_n
module core_ctrl_fsm
  import instruction_utils::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned INSTRET_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  input  rv32i_instr_e         instr,
  input  logic                 illegal,
  input  logic                 branch_taken,
  output logic                 imem_req,
  input  logic                 imem_ready,
  output logic                 ir_we,
  output logic                 op_we,
  output logic                 dmem_req,
  output logic                 dmem_we,
  input  logic                 dmem_ready,
  output logic                 rf_we,
  output logic [1:0]           wb_sel,
  output logic                 pc_we,
  output logic [1:0]           pc_sel,
  output logic                 retire,
  output logic [INSTRET_W-1:0] instret,
  output logic                 halt,
  output logic [1:0]           trap_cause
);

  localparam int unsigned CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_IMEM    = 2'd2;
  localparam logic [1:0] CAUSE_DMEM    = 2'd3;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_RS1   = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_e;

  typedef enum logic [2:0] {
    C_ALU, C_JAL, C_JALR, C_BRANCH, C_LOAD, C_STORE, C_BAD
  } iclass_e;

  state_e           state;
  iclass_e          iclass;
  logic [CNT_W-1:0] wait_cnt;

  always_comb begin
    iclass = C_BAD;
    case (instr)
      I_LUI, I_AUIPC,
      I_ADDI, I_SLTI, I_SLTIU, I_XORI, I_ORI, I_ANDI, I_SLLI, I_SRLI, I_SRAI,
      I_ADD, I_SUB, I_SLL, I_SLT, I_SLTU, I_XOR, I_SRL, I_SRA, I_OR, I_AND:
        iclass = C_ALU;
      I_JAL:  iclass = C_JAL;
      I_JALR: iclass = C_JALR;
      I_BEQ, I_BNE, I_BLT, I_BGE, I_BLTU, I_BGEU:
        iclass = C_BRANCH;
      I_LB, I_LH, I_LW, I_LBU, I_LHU:
        iclass = C_LOAD;
      I_SB, I_SH, I_SW:
        iclass = C_STORE;
      default: iclass = C_BAD;
    endcase
  end

  // Strobes are pure decodes of state (plus instr/branch_taken/ready), so an async
  // reset removes them in the same instant the state register clears.
  always_comb begin
    imem_req = 1'b0;
    ir_we    = 1'b0;
    op_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    wb_sel   = WB_ALU;
    pc_we    = 1'b0;
    pc_sel   = PC_PLUS4;
    retire   = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ready;
      end
      S_DECODE: op_we = 1'b1;
      S_EXEC: begin
        case (iclass)
          C_ALU: begin
            rf_we  = 1'b1;
            pc_we  = 1'b1;
            retire = 1'b1;
          end
          C_JAL, C_JALR: begin
            rf_we  = 1'b1;
            wb_sel = WB_PC4;
            pc_we  = 1'b1;
            pc_sel = (iclass == C_JAL) ? PC_IMM : PC_RS1;
            retire = 1'b1;
          end
          C_BRANCH: begin
            pc_we  = 1'b1;
            pc_sel = branch_taken ? PC_IMM : PC_PLUS4;
            retire = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (iclass == C_STORE);
        if (dmem_ready && iclass == C_STORE) begin
          pc_we  = 1'b1;
          retire = 1'b1;
        end
      end
      S_WB: begin
        rf_we  = 1'b1;
        wb_sel = WB_LOAD;
        pc_we  = 1'b1;
        retire = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      instret    <= '0;
      halt       <= 1'b0;
      trap_cause <= CAUSE_NONE;
    end else begin
      if (retire) instret <= instret + INSTRET_W'(1);
      case (state)
        S_IDLE: begin
          if (run) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
          end
        end
        S_FETCH: begin
          if (imem_ready) begin
            state <= S_DECODE;
          end else if (wait_cnt == CNT_MAX) begin
            state      <= S_TRAP;
            halt       <= 1'b1;
            trap_cause <= CAUSE_IMEM;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        S_DECODE: begin
          if (illegal) begin
            state      <= S_TRAP;
            halt       <= 1'b1;
            trap_cause <= CAUSE_ILLEGAL;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (iclass)
            C_LOAD, C_STORE: begin
              state    <= S_MEM;
              wait_cnt <= '0;
            end
            C_ALU, C_JAL, C_JALR, C_BRANCH: begin
              state    <= S_FETCH;
              wait_cnt <= '0;
            end
            // Unreachable with a consistent decoder; treated as illegal rather than hanging.
            default: begin
              state      <= S_TRAP;
              halt       <= 1'b1;
              trap_cause <= CAUSE_ILLEGAL;
            end
          endcase
        end
        S_MEM: begin
          if (dmem_ready) begin
            state    <= (iclass == C_STORE) ? S_FETCH : S_WB;
            wait_cnt <= '0;
          end else if (wait_cnt == CNT_MAX) begin
            state      <= S_TRAP;
            halt       <= 1'b1;
            trap_cause <= CAUSE_DMEM;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        S_WB: begin
          state    <= S_FETCH;
          wait_cnt <= '0;
        end
        S_TRAP: ;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
